cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_arbiter.sv | 119 +++++++++++
 tb/tb_cache_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and line geometry for the I/D cache-to-burst-memory arbiter.
package cache_pkg;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEAT_W * BEATS;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_ICACHE,
    REQ_DCACHE
  } req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter multiplexing icache line reads and dcache line reads/writebacks
// onto a single burst-memory port; one line per grant, BEATS beats per line.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = cache_pkg::BEAT_W,
  parameter int BEATS  = cache_pkg::BEATS
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [ADDR_W-1:0]         icache_address,
  input  logic                      icache_read,
  output logic [BEAT_W*BEATS-1:0]   icache_rdata,
  output logic                      icache_resp,

  input  logic [ADDR_W-1:0]         dcache_address,
  input  logic                      dcache_read,
  input  logic                      dcache_write,
  input  logic [BEAT_W*BEATS-1:0]   dcache_wdata,
  output logic [BEAT_W*BEATS-1:0]   dcache_rdata,
  output logic                      dcache_resp,

  output logic [ADDR_W-1:0]         bmem_address,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic [BEAT_W-1:0]         bmem_rdata,
  input  logic                      bmem_resp
);

  import cache_pkg::*;

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'h1f);

  arb_state_t               state_q, state_d;
  logic [CNT_W-1:0]         beat_q, beat_d;
  req_t                     last_q, owner_q, grant_port;
  logic                     do_grant, grant_wr;
  logic [ADDR_W-1:0]        addr_q;
  logic [BEAT_W*BEATS-1:0]  wdata_q;
  logic [BEAT_W*BEATS-1:0]  line_q;

  logic i_pend, d_pend;
  assign i_pend = icache_read;
  assign d_pend = dcache_read | dcache_write;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    do_grant   = 1'b0;
    grant_port = REQ_ICACHE;
    grant_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          do_grant = 1'b1;
          if (i_pend && d_pend)
            grant_port = (last_q == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
          else
            grant_port = d_pend ? REQ_DCACHE : REQ_ICACHE;
          // read+write together on dcache is resolved as a writeback
          grant_wr = (grant_port == REQ_DCACHE) && dcache_write;
          state_d  = grant_wr ? WR_BURST : RD_BURST;
          beat_d   = '0;
        end
      end
      RD_BURST, WR_BURST: begin
        if (bmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= REQ_ICACHE;
      owner_q <= REQ_ICACHE;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (do_grant) begin
        owner_q <= grant_port;
        last_q  <= grant_port;
        addr_q  <= ((grant_port == REQ_DCACHE) ? dcache_address : icache_address) & ALIGN_MASK;
        if (grant_wr)
          wdata_q <= dcache_wdata;
      end
      if ((state_q == RD_BURST) && bmem_resp)
        line_q[beat_q*BEAT_W +: BEAT_W] <= bmem_rdata;
    end
  end

  always_comb begin
    bmem_read    = (state_q == RD_BURST);
    bmem_write   = (state_q == WR_BURST);
    bmem_address = (bmem_read || bmem_write) ? addr_q : '0;
    bmem_wdata   = bmem_write ? wdata_q[beat_q*BEAT_W +: BEAT_W] : '0;
    icache_resp  = (state_q == DONE) && (owner_q == REQ_ICACHE);
    dcache_resp  = (state_q == DONE) && (owner_q == REQ_DCACHE);
    icache_rdata = line_q;
    dcache_rdata = line_q;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench: cache-side request models with per-port scoreboards and a burst-memory model.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEAT_W * BEATS;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rline;
    bit                chk_lat;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] icache_address, dcache_address, bmem_address;
  logic              icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
  logic [LINE_W-1:0] icache_rdata, dcache_rdata, dcache_wdata;
  logic              bmem_read, bmem_write, bmem_resp;
  logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

  txn_t iq[$], dq[$];
  txn_t icur, dcur;
  bit   iact = 1'b0, dact = 1'b0;
  int   ireq_cyc = 0, dreq_cyc = 0;
  int   order[$];
  int   errors = 0, checks = 0, cyc = 0, wr_cycles = 0;

  logic [LINE_W-1:0] mem_line = '0;
  int   stall = 0, idx = 0, wcnt = 0;
  logic spur = 1'b0, mem_resp = 1'b0;

  cache_arbiter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .icache_address(icache_address), .icache_read(icache_read),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_address(dcache_address), .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst memory: one cycle to first beat, then `stall` idle cycles between beats.
  assign bmem_resp  = mem_resp | spur;
  assign bmem_rdata = mem_line[(idx & 3)*BEAT_W +: BEAT_W];

  always @(posedge clk) begin
    if (rst || !(bmem_read || bmem_write)) begin
      mem_resp <= 1'b0;
      idx      <= 0;
      wcnt     <= 0;
    end else begin
      if (mem_resp) idx <= idx + 1;
      if (mem_resp && stall != 0) begin
        mem_resp <= 1'b0;
        wcnt     <= stall - 1;
      end else if (!mem_resp && wcnt != 0) begin
        wcnt <= wcnt - 1;
      end else begin
        mem_resp <= 1'b1;
      end
    end
  end

  assign icache_read    = iact;
  assign icache_address = icur.addr;
  assign dcache_read    = dact && !dcur.wr;
  assign dcache_write   = dact && dcur.wr;
  assign dcache_address = dcur.addr;
  assign dcache_wdata   = dcur.wdata;

  // Monitors first, then the cache models retire/issue requests on the same edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bmem_write) begin
        wr_cycles++;
        chk("wr_dir", dcache_write, 1'b1);
        chk("wr_addr", bmem_address, {dcache_address[ADDR_W-1:5], 5'b0});
        chk("wr_beat", bmem_wdata, dcache_wdata[(idx & 3)*BEAT_W +: BEAT_W]);
      end
      if (bmem_read)
        chk("rd_addr", (icache_read && bmem_address == {icache_address[ADDR_W-1:5], 5'b0}) ||
                       (dcache_read && bmem_address == {dcache_address[ADDR_W-1:5], 5'b0}), 1'b1);
      chk("resp_excl", icache_resp && dcache_resp, 1'b0);
      if (icache_resp) begin
        chk("i_resp_expected", iact, 1'b1);
        chk("i_rdata", icache_rdata, icur.rline);
        if (icur.chk_lat) chk("i_latency", cyc - ireq_cyc, 6);
        order.push_back(0);
        iact = 1'b0;
      end
      if (dcache_resp) begin
        chk("d_resp_expected", dact, 1'b1);
        if (!dcur.wr) chk("d_rdata", dcache_rdata, dcur.rline);
        order.push_back(1);
        dact = 1'b0;
      end
    end
    if (!iact && iq.size() > 0) begin
      icur = iq.pop_front();
      iact = 1'b1;
      ireq_cyc = cyc;
    end
    if (!dact && dq.size() > 0) begin
      dcur = dq.pop_front();
      dact = 1'b1;
      dreq_cyc = cyc;
    end
  end

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((iact || dact || iq.size() > 0 || dq.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < 300, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LINE_W-1:0] line1, wline;
    int n;
    icur = '{1'b0, '0, '0, '0, 1'b0};
    dcur = '{1'b0, '0, '0, '0, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iresp", icache_resp, 1'b0);
    chk("rst_dresp", dcache_resp, 1'b0);
    chk("rst_bread", bmem_read, 1'b0);
    chk("rst_bwrite", bmem_write, 1'b0);
    chk("rst_irdata", icache_rdata, '0);
    chk("rst_drdata", dcache_rdata, '0);
    chk("rst_baddr", bmem_address, '0);
    chk("rst_bwdata", bmem_wdata, '0);
    @(posedge clk); #1 rst = 1'b0;

    // icache-only read, unaligned address, latency from request assertion
    line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem_line = line1;
    iq.push_back('{1'b0, 32'h6000_0044, '0, line1, 1'b1});
    n = 0;
    do begin @(negedge clk); n++; end while (!bmem_read && n < 20);
    chk("t1_addr", bmem_address, 32'h6000_0040);
    wait_quiet("t1");
    chk("t1_hold", icache_rdata, line1);

    // simultaneous icache read + dcache write right after reset: dcache first
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t2_rst_rdata", icache_rdata, '0);
    mem_line = {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000};
    wline = {64'hD00D_0000_0000_0004, 64'hD00D_0000_0000_0003,
             64'hD00D_0000_0000_0002, 64'hD00D_0000_0000_0001};
    order.delete();
    dq.push_back('{1'b1, 32'h1000_0020, wline, '0, 1'b0});
    iq.push_back('{1'b0, 32'h2000_0008, '0, mem_line, 1'b0});
    wait_quiet("t2");
    chk("t2_count", order.size(), 2);
    chk("t2_first_d", order[0], 1);
    chk("t2_second_i", order[1], 0);
    chk("t2_hold_after_wr", icache_rdata, mem_line);

    // writeback with 2-cycle stalls between beats
    stall = 2;
    wr_cycles = 0;
    wline = {64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002,
             64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000};
    dq.push_back('{1'b1, 32'h1234_5678, wline, '0, 1'b0});
    wait_quiet("t3");
    chk("t3_wr_cycles", wr_cycles, 1 + BEATS + 2*(BEATS-1));
    stall = 0;

    // both ports saturated for 8 transactions: strict alternation
    order.delete();
    for (int k = 0; k < 4; k++) begin
      iq.push_back('{1'b0, 32'h7000_0000 + 32'(k*64), '0, mem_line, 1'b0});
      dq.push_back('{(k % 2 == 0), 32'h8000_0004 + 32'(k*64),
                     {8{32'(32'hA5A5_0000 + k)}}, mem_line, 1'b0});
    end
    wait_quiet("t4");
    chk("t4_count", order.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4_grant%0d", k), order[k], k % 2);

    // reset after beat 1 of a read; request held and re-served afterwards
    iq.push_back('{1'b0, 32'h0000_1000, '0, mem_line, 1'b0});
    n = 0;
    do begin @(negedge clk); n++; end while (idx != 2 && n < 30);
    chk("t5_reach_beat2", idx, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_bread", bmem_read, 1'b0);
    chk("t5_iresp", icache_resp, 1'b0);
    chk("t5_rdata_clr", icache_rdata, '0);
    rst = 1'b0;
    wait_quiet("t5");

    // spurious bmem_resp while idle
    #1 spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_iresp", icache_resp, 1'b0);
      chk("t6_dresp", dcache_resp, 1'b0);
      chk("t6_bread", bmem_read, 1'b0);
      chk("t6_bwrite", bmem_write, 1'b0);
    end
    @(posedge clk); #1 spur = 1'b0;
    iq.push_back('{1'b0, 32'h6000_00A0, '0, mem_line, 1'b1});
    wait_quiet("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
